// File: rtl/led_pwm_fader.sv
// led_pwm_fader: PWM LED driver that slews its applied duty toward the latest
// sampled brightness target, one code every FADE_PERIODS PWM periods, with duty
// updates confined to period boundaries so each period is glitch-free.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   brightness    requested duty code (saturated to PERIOD when sampled)
//   load          samples brightness into the target register
//   pwm_out       registered PWM drive, high for the first level*PRESCALE clocks
//   level         duty code currently applied
//   period_start  one-cycle pulse in the first cycle of each PWM period
//   fading        high while level differs from target
module led_pwm_fader #(
    parameter int unsigned PRESCALE     = 4,
    parameter int unsigned PERIOD       = 50,
    parameter int unsigned FADE_PERIODS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] brightness,
    input  logic       load,
    output logic       pwm_out,
    output logic [5:0] level,
    output logic       period_start,
    output logic       fading
);

    localparam int unsigned PRESC_W = 8;
    localparam int unsigned CODE_W  = 6;
    localparam int unsigned FADE_W  = 8;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [CODE_W-1:0]  TICK_LAST  = CODE_W'(PERIOD - 1);
    localparam logic [CODE_W-1:0]  DUTY_MAX   = CODE_W'(PERIOD);
    localparam logic [FADE_W-1:0]  FADE_LAST  = FADE_W'(FADE_PERIODS - 1);

    logic [PRESC_W-1:0] presc_q,    presc_d;
    logic [CODE_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [FADE_W-1:0]  fade_cnt_q, fade_cnt_d;
    logic [CODE_W-1:0]  target_q,   target_d;
    logic [CODE_W-1:0]  level_d;
    logic               started_q;
    logic               pwm_d;
    logic               period_start_d;

    logic tick;
    logic boundary;
    logic slew_step;

    // Next-state logic for the period timing, slew and PWM compare
    always_comb begin
        tick           = 1'b0;
        boundary       = 1'b0;
        slew_step      = 1'b0;
        presc_d        = presc_q;
        tick_cnt_d     = tick_cnt_q;
        fade_cnt_d     = fade_cnt_q;
        target_d       = target_q;
        level_d        = level;
        pwm_d          = 1'b0;
        period_start_d = 1'b0;

        tick      = (presc_q == PRESC_LAST);
        boundary  = tick && (tick_cnt_q == TICK_LAST);
        slew_step = boundary && (fade_cnt_q == FADE_LAST);

        presc_d = tick ? '0 : presc_q + PRESC_W'(1);

        if (tick) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + CODE_W'(1);
        end

        if (boundary) begin
            fade_cnt_d = (fade_cnt_q == FADE_LAST) ? '0 : fade_cnt_q + FADE_W'(1);
        end

        // A load coinciding with a step is only seen at the next qualifying boundary
        if (load) begin
            target_d = (brightness > DUTY_MAX) ? DUTY_MAX : brightness;
        end

        // Move one code toward the registered target; level stays within 0..PERIOD
        if (slew_step) begin
            if (level < target_q) begin
                level_d = level + CODE_W'(1);
            end else if (level > target_q) begin
                level_d = level - CODE_W'(1);
            end
        end

        // Compare against next-cycle values so the output is aligned to the period
        pwm_d = (tick_cnt_d < level_d);

        // First cycle after reset release also counts as a period start
        period_start_d = boundary || !started_q;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            tick_cnt_q   <= '0;
            fade_cnt_q   <= '0;
            target_q     <= '0;
            level        <= '0;
            started_q    <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            tick_cnt_q   <= tick_cnt_d;
            fade_cnt_q   <= fade_cnt_d;
            target_q     <= target_d;
            level        <= level_d;
            started_q    <= 1'b1;
            pwm_out      <= pwm_d;
            period_start <= period_start_d;
        end
    end

    assign fading = (level != target_q);

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed bench for led_pwm_fader. Instance A uses default
// parameters; instance B uses PRESCALE=1, FADE_PERIODS=1 for fast boundary tests.
module tb_led_pwm_fader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       load_a, load_b;
    logic [5:0] br_a, br_b;
    logic       pwm_a, pwm_b;
    logic [5:0] lvl_a, lvl_b;
    logic       ps_a, ps_b;
    logic       fad_a, fad_b;

    led_pwm_fader u_dut_a (
        .clk          (clk),
        .rst          (rst_a),
        .brightness   (br_a),
        .load         (load_a),
        .pwm_out      (pwm_a),
        .level        (lvl_a),
        .period_start (ps_a),
        .fading       (fad_a)
    );

    led_pwm_fader #(
        .PRESCALE     (1),
        .PERIOD       (50),
        .FADE_PERIODS (1)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .brightness   (br_b),
        .load         (load_b),
        .pwm_out      (pwm_b),
        .level        (lvl_b),
        .period_start (ps_b),
        .fading       (fad_b)
    );

    // Selected DUT view used by the shared tasks
    logic       sel;
    logic       m_ps, m_pwm, m_fad;
    logic [5:0] m_lvl;
    int         plen, pmul;
    assign m_ps  = sel ? ps_b  : ps_a;
    assign m_pwm = sel ? pwm_b : pwm_a;
    assign m_fad = sel ? fad_b : fad_a;
    assign m_lvl = sel ? lvl_b : lvl_a;
    assign plen  = sel ? 50 : 200;
    assign pmul  = sel ? 1 : 4;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive load for one rising edge, then return at the following falling edge
    task automatic do_load(input int b);
        if (sel) begin
            br_b   = 6'(b);
            load_b = 1'b1;
        end else begin
            br_a   = 6'(b);
            load_a = 1'b1;
        end
        @(posedge clk);
        #1;
        load_a = 1'b0;
        load_b = 1'b0;
        @(negedge clk);
    endtask

    // Wait for a period start, then report its level and pwm high count
    task automatic measure(input string tag, output int lvl, output int highs);
        int n;
        n = 0;
        while (!m_ps && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ps_wait"}, int'(m_ps), 1);
        lvl   = int'(m_lvl);
        highs = 0;
        for (int i = 0; i < plen; i++) begin
            highs += int'(m_pwm);
            @(negedge clk);
        end
    endtask

    task automatic check_period(input int k, input int exp_lvl);
        int l, h;
        string tag;
        tag = $sformatf("%s_p%0d", sel ? "B" : "A", k);
        measure(tag, l, h);
        check({tag, "_level"}, l, exp_lvl);
        check({tag, "_highs"}, h, exp_lvl * pmul);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, h;
        sel    = 1'b0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        load_a = 1'b0;
        load_b = 1'b0;
        br_a   = '0;
        br_b   = '0;
        repeat (3) @(negedge clk);

        // Instance A: reset values
        check("A_rst_level", int'(lvl_a), 0);
        check("A_rst_pwm",   int'(pwm_a), 0);
        check("A_rst_ps",    int'(ps_a),  0);
        check("A_rst_fad",   int'(fad_a), 0);
        rst_a = 1'b0;
        @(negedge clk);
        check("A_rel_ps",  int'(ps_a),  1);
        check("A_rel_pwm", int'(pwm_a), 0);

        // Fade up to 10: one code every 2 periods
        do_load(10);
        check("A_up_fad0", int'(fad_a), 1);
        check("A_up_lvl0", int'(lvl_a), 0);
        for (int k = 1; k <= 21; k++) check_period(k, (k / 2 > 10) ? 10 : k / 2);
        check("A_up_done_fad", int'(fad_a), 0);

        // Saturation: 60 becomes 50, then full duty with no wrap dropout
        do_load(60);
        check("A_sat_fad", int'(fad_a), 1);
        for (int k = 23; k <= 104; k++) begin
            e = 10 + (k - 22) / 2;
            check_period(k, (e > 50) ? 50 : e);
        end
        check("A_sat_fad_end", int'(fad_a), 0);
        check("A_sat_lvl_end", int'(lvl_a), 50);

        // Fade down to zero over 100 periods
        do_load(0);
        for (int k = 106; k <= 206; k++) begin
            e = 50 - (k - 104) / 2;
            check_period(k, (e < 0) ? 0 : e);
        end
        check("A_dn_fad_end", int'(fad_a), 0);
        h = 0;
        for (int i = 0; i < 400; i++) begin
            h += int'(pwm_a);
            @(negedge clk);
        end
        check("A_dn_pwm_low", h, 0);

        // Instance B: PRESCALE=1, FADE_PERIODS=1
        sel   = 1'b1;
        rst_b = 1'b0;
        @(negedge clk);
        check("B_rel_ps", int'(ps_b), 1);
        do_load(5);
        for (int k = 1; k <= 6; k++) check_period(k, (k > 5) ? 5 : k);

        // Load on the boundary cycle (last cycle of period 7)
        repeat (49) @(negedge clk);
        do_load(8);
        check("B_bnd_ps",    int'(ps_b),  1);
        check("B_bnd_level", int'(lvl_b), 5);
        for (int k = 8; k <= 12; k++) check_period(k, (k - 3 > 8) ? 8 : k - 3);

        // Retarget mid-fade: up toward 20, then down to 3 from level 12
        do_load(20);
        for (int k = 14; k <= 16; k++) check_period(k, 8 + (k - 13));
        check("B_rt_lvl12", int'(lvl_b), 12);
        do_load(3);
        for (int k = 18; k <= 28; k++) begin
            e = 12 - (k - 17);
            check_period(k, (e < 3) ? 3 : e);
        end
        check("B_rt_fad_end", int'(fad_b), 0);

        // Climb to 30, then reset asynchronously mid-period
        do_load(40);
        for (int k = 30; k <= 55; k++) check_period(k, 3 + (k - 29));
        repeat (5) @(negedge clk);
        check("B_pre_rst_lvl", int'(lvl_b), 30);
        check("B_pre_rst_pwm", int'(pwm_b), 1);
        check("B_pre_rst_fad", int'(fad_b), 1);
        #2;
        rst_b = 1'b1;
        #1;
        check("B_arst_level", int'(lvl_b), 0);
        check("B_arst_pwm",   int'(pwm_b), 0);
        check("B_arst_ps",    int'(ps_b),  0);
        check("B_arst_fad",   int'(fad_b), 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check("B_rel2_ps",  int'(ps_b),  1);
        check("B_rel2_pwm", int'(pwm_b), 0);
        check("B_rel2_lvl", int'(lvl_b), 0);
        @(negedge clk);
        check("B_rel2_ps_drop", int'(ps_b), 0);
        h = 0;
        for (int i = 0; i < 120; i++) begin
            h += int'(pwm_b);
            @(negedge clk);
        end
        check("B_rel2_pwm_low", h, 0);
        check("B_rel2_lvl_end", int'(lvl_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Consumes the 6-bit brightness code from the upstream brightness generator and drives one LED via PWM.
- The applied duty ramps toward the latest sampled brightness target at a controlled slew rate, so LED steps are visibly smooth.
- Duty changes only at PWM period boundaries, which keeps every period glitch-free.
- Sits between the brightness source and the board LED pin.

Parameters:
- PRESCALE, 4, clock cycles per PWM tick; legal range 1 to 255.
- PERIOD, 50, PWM ticks per period and the maximum duty code; legal range 2 to 63.
- FADE_PERIODS, 2, number of PWM periods between successive 1-code slew steps; legal range 1 to 255.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- brightness  in  6  requested duty code from the upstream stage.
- load  in  1  when high on a clock edge, brightness is sampled into the target register.
- pwm_out  out  1  registered PWM drive to the LED.
- level  out  6  duty code currently being applied.
- period_start  out  1  one-cycle pulse in the first cycle of each PWM period.
- fading  out  1  high while level != target.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-high (rst).
  - Asserting rst immediately clears the prescaler, tick_cnt, fade_cnt, target, level, pwm_out, period_start and fading to 0.
  - On release, a new period starts from tick_cnt=0.
  - Reset mid-fade abandons the fade. No state survives reset.
- Prescaler: counts 0..PRESCALE-1 and wraps.
  - tick is high in the cycle where the prescaler equals PRESCALE-1.
  - With PRESCALE=1, tick is high every cycle.
- Tick counter (tick_cnt): counts 0..PERIOD-1, advances on tick, wraps to 0.
  - boundary = tick AND tick_cnt==PERIOD-1.
  - One period lasts PRESCALE*PERIOD clocks (200 at the defaults).
- Target: on load, target <= min(brightness, PERIOD). Codes above PERIOD saturate to PERIOD.
  - Without load, target holds.
- Slew: fade_cnt counts boundaries from 0 to FADE_PERIODS-1 and wraps.
  - At a boundary where fade_cnt==FADE_PERIODS-1, level moves 1 toward target: +1 if level<target, -1 if level>target, unchanged if equal.
  - level never changes at any other time.
- Simultaneous load and boundary: the step uses the old registered target. The new target is first used at the next qualifying boundary.
- PWM output: pwm_out <= (next tick_cnt < next level), registered.
  - pwm_out is aligned to the period: high for the first level*PRESCALE clocks of each period, low for the rest.
  - level=0 gives pwm_out constantly low. level=PERIOD gives pwm_out constantly high, with no one-cycle dropout at the wrap.
- period_start is registered and high exactly in the cycle tick_cnt becomes 0 after a boundary.
  - It is also high in the first cycle after reset release.
- fading is combinational from registered level and target: fading = (level != target).
- Widths: the prescaler is 8 bits and fade_cnt is 8 bits. tick_cnt, level and target are 6 bits.
  - Comparisons are unsigned. No arithmetic may wrap: level is bounded to 0..PERIOD by construction.

Test Plan:
- Reset values: assert rst mid-operation with level=30 → all outputs read 0 in the same cycle, asynchronously, before the next clk edge. After release, period_start pulses in the first cycle and pwm_out stays low.
- Fade up, defaults: load brightness=10 from reset → level increments once every 2 periods (400 clocks).
  - level reaches 10 after 20 periods (4000 clocks) and fading then drops.
  - Each period has exactly level*4 high cycles of pwm_out.
- Saturation and full duty: load brightness=60 and let the fade complete → target=50, level settles at 50, pwm_out constantly high across at least 3 period wraps.
- Fade down and zero: from level=50, load brightness=0 → level decrements to 0 in 100 periods, then pwm_out is constantly low and fading=0.
- Simultaneous load at boundary: with FADE_PERIODS=1, level=5 and target=5, pulse load with brightness=8 on a boundary cycle → level stays 5 for that boundary, then reaches 6, 7 and 8 on the next 3 boundaries.
- Retarget mid-fade: with FADE_PERIODS=1 and level rising toward 20, load brightness=3 when level=12 → level decrements from the next boundary and reaches 3 after 9 boundaries, with no overshoot.
